// File: rtl/flash_pkg.sv
// Shared constants and state encoding for the flash program/erase sequencer.
// Erase command words exist only when FLASH_ERASE_EN is defined.
package flash_pkg;

  localparam logic [15:0] CMD_PROGRAM  = 16'h0040;
`ifdef FLASH_ERASE_EN
  localparam logic [15:0] CMD_ERASE    = 16'h0020;
  localparam logic [15:0] CMD_CONFIRM  = 16'h00D0;
`endif
  localparam logic [15:0] CMD_CLR_SR   = 16'h0050;
  localparam logic [15:0] CMD_RD_ARRAY = 16'h00FF;

  localparam int SR7 = 7;
  localparam int SR5 = 5;
  localparam int SR4 = 4;
  localparam int SR3 = 3;

  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WR_GAP,
    POLL_RD,
    POLL_CHK,
    CLR_SR,
    RD_ARRAY,
    FIN
  } state_t;

endpackage

// File: rtl/flash_wr_cycle.sv
// One flash bus write: setup, WE# low for WE_CYC cycles, hold, CE# gap.
// ack is high during the gap cycle so the caller can queue the next word.
module flash_wr_cycle
  import flash_pkg::*;
#(
  parameter int WE_CYC = 7
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic [15:0] data,
  output logic        ack,
  output logic        we,
  output logic        ce,
  output logic        dq_drv,
  output logic [15:0] dq_out
);

  localparam int CW = $clog2(WE_CYC + 1);

  state_t          phase_reg;
  logic [CW-1:0]   cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      phase_reg <= IDLE;
      cnt_reg   <= '0;
      ack       <= 1'b0;
      we        <= 1'b1;
      ce        <= 1'b1;
      dq_drv    <= 1'b0;
      dq_out    <= '0;
    end else begin
      ack <= 1'b0;
      case (phase_reg)
        IDLE: begin
          if (start) begin
            phase_reg <= WR_SETUP;
            ce        <= 1'b0;
            dq_drv    <= 1'b1;
            dq_out    <= data;
          end
        end
        WR_SETUP: begin
          phase_reg <= WR_PULSE;
          we        <= 1'b0;
          cnt_reg   <= '0;
        end
        WR_PULSE: begin
          if (cnt_reg == CW'(WE_CYC - 1)) begin
            phase_reg <= WR_HOLD;
            we        <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WR_HOLD: begin
          phase_reg <= WR_GAP;
          ce        <= 1'b1;
          dq_drv    <= 1'b0;
          ack       <= 1'b1;
        end
        default: phase_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/flash_prog.sv
// Word-program / block-erase sequencer for a parallel NOR flash with status polling.
// Block erase is serviced only when FLASH_ERASE_EN is defined.
module flash_prog
  import flash_pkg::*;
#(
  parameter int WE_CYC   = 7,
  parameter int RD_CYC   = 11,
  parameter int POLL_MAX = 1 << 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PROG_GO,
  input  logic        ERASE_GO,
  input  logic [23:1] PROG_ADDR,
  input  logic [15:0] PROG_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [2:0]  ERR_CODE,
  output logic [23:1] ADDR,
  output logic [15:0] DQ_OUT,
  output logic        DQ_DRV,
  input  logic [15:0] DQ_IN,
  output logic        OE,
  output logic        WE,
  output logic        CE,
  output logic        RP,
  output logic        MTCE
);

  localparam int RW = $clog2(RD_CYC + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  state_t        state_reg;
  logic          busy_reg, done_reg, err_reg;
  logic [2:0]    err_code_reg;
  logic [23:1]   addr_reg;
  logic          start_reg;
  logic [15:0]   cmd_reg;
  logic [15:0]   second_word_reg;
  logic          second_pending_reg;
  logic          oe_reg, poll_ce_reg;
  logic [RW-1:0] rd_cnt_reg;
  logic [PW-1:0] poll_cnt_reg;
  logic          sr7_reg;
  logic [2:0]    sr_err_reg;

  logic          go;
  logic [15:0]   first_word, second_word;
  logic          wr_ack, wr_we, wr_ce, wr_dq_drv;
  logic [15:0]   wr_dq_out;
  logic [11:0]   dq_in_unused;

`ifdef FLASH_ERASE_EN
  assign go          = PROG_GO | ERASE_GO;
  assign first_word  = ERASE_GO ? CMD_ERASE   : CMD_PROGRAM;
  assign second_word = ERASE_GO ? CMD_CONFIRM : PROG_DATA;
`else
  logic erase_go_unused;
  assign erase_go_unused = ERASE_GO;
  assign go          = PROG_GO;
  assign first_word  = CMD_PROGRAM;
  assign second_word = PROG_DATA;
`endif

  assign dq_in_unused = {DQ_IN[15:8], DQ_IN[6], DQ_IN[2:0]};

  flash_wr_cycle #(.WE_CYC(WE_CYC)) u_wr_cycle (
    .clk    (CLK),
    .srst   (RST),
    .start  (start_reg),
    .data   (cmd_reg),
    .ack    (wr_ack),
    .we     (wr_we),
    .ce     (wr_ce),
    .dq_drv (wr_dq_drv),
    .dq_out (wr_dq_out)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg          <= IDLE;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      err_reg            <= 1'b0;
      err_code_reg       <= '0;
      addr_reg           <= '0;
      start_reg          <= 1'b0;
      cmd_reg            <= '0;
      second_word_reg    <= '0;
      second_pending_reg <= 1'b0;
      oe_reg             <= 1'b1;
      poll_ce_reg        <= 1'b1;
      rd_cnt_reg         <= '0;
      poll_cnt_reg       <= '0;
      sr7_reg            <= 1'b0;
      sr_err_reg         <= '0;
    end else begin
      start_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            state_reg          <= WR_SETUP;
            busy_reg           <= 1'b1;
            err_reg            <= 1'b0;
            err_code_reg       <= '0;
            addr_reg           <= PROG_ADDR;
            cmd_reg            <= first_word;
            second_word_reg    <= second_word;
            second_pending_reg <= 1'b1;
            start_reg          <= 1'b1;
          end
        end
        // Command-word pair; the second word is queued on the first write's ack.
        WR_SETUP: begin
          if (wr_ack) begin
            if (second_pending_reg) begin
              start_reg          <= 1'b1;
              cmd_reg            <= second_word_reg;
              second_pending_reg <= 1'b0;
            end else begin
              state_reg    <= POLL_RD;
              oe_reg       <= 1'b0;
              poll_ce_reg  <= 1'b0;
              rd_cnt_reg   <= '0;
              poll_cnt_reg <= '0;
            end
          end
        end
        POLL_RD: begin
          if (rd_cnt_reg == RW'(RD_CYC - 1)) begin
            state_reg   <= POLL_CHK;
            oe_reg      <= 1'b1;
            poll_ce_reg <= 1'b1;
            sr7_reg     <= DQ_IN[SR7];
            sr_err_reg  <= {DQ_IN[SR5], DQ_IN[SR4], DQ_IN[SR3]};
          end else begin
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
          end
        end
        // SR7 is judged before the timeout so a status ready on the last poll still counts.
        POLL_CHK: begin
          if (!sr7_reg) begin
            if (poll_cnt_reg == PW'(POLL_MAX - 1)) begin
              err_reg      <= 1'b1;
              err_code_reg <= 3'b111;
              state_reg    <= CLR_SR;
              cmd_reg      <= CMD_CLR_SR;
              start_reg    <= 1'b1;
            end else begin
              poll_cnt_reg <= poll_cnt_reg + 1'b1;
              rd_cnt_reg   <= '0;
              oe_reg       <= 1'b0;
              poll_ce_reg  <= 1'b0;
              state_reg    <= POLL_RD;
            end
          end else if (|sr_err_reg) begin
            err_reg      <= 1'b1;
            err_code_reg <= sr_err_reg;
            state_reg    <= CLR_SR;
            cmd_reg      <= CMD_CLR_SR;
            start_reg    <= 1'b1;
          end else begin
            state_reg <= RD_ARRAY;
            cmd_reg   <= CMD_RD_ARRAY;
            start_reg <= 1'b1;
          end
        end
        CLR_SR: begin
          if (wr_ack) begin
            state_reg <= RD_ARRAY;
            cmd_reg   <= CMD_RD_ARRAY;
            start_reg <= 1'b1;
          end
        end
        RD_ARRAY: begin
          if (wr_ack) begin
            state_reg <= FIN;
            done_reg  <= 1'b1;
          end
        end
        FIN: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign BUSY     = busy_reg;
  assign DONE     = done_reg;
  assign ERR      = err_reg;
  assign ERR_CODE = err_code_reg;
  assign ADDR     = addr_reg;
  assign DQ_OUT   = wr_dq_out;
  assign DQ_DRV   = wr_dq_drv;
  assign OE       = oe_reg;
  assign WE       = wr_we;
  assign CE       = wr_ce & poll_ce_reg;
  assign RP       = 1'b1;
  assign MTCE     = 1'b1;

endmodule

// File: doc/flash_prog.md
FLASH_PROG -- requirements
Module: flash_prog

Interface
REQ-001 Parameter WE_CYC, default 7, meaning WE# low width in CLK cycles (70 ns at 100 MHz).
REQ-002 Parameter RD_CYC, default 11, meaning OE#-to-data-valid wait in CLK cycles for status reads.
REQ-003 Parameter POLL_MAX, default 2^20, meaning status-poll limit before a timeout error.
REQ-004 Port list (name, direction, width, meaning):
- CLK, in, 1: 100 MHz clock.
- RST, in, 1: reset; synchronous, active-high.
- PROG_GO, in, 1: one-cycle request to program one word.
- ERASE_GO, in, 1: one-cycle request to erase the block containing PROG_ADDR.
- PROG_ADDR, in, 23 ([23:1]): word address.
- PROG_DATA, in, 16: word to write.
- BUSY, out, 1: an operation is in progress.
- DONE, out, 1: one-cycle pulse when an operation ends.
- ERR, out, 1: sticky error flag.
- ERR_CODE, out, 3: status bits {SR5, SR4, SR3}, or 3'b111 on timeout.
- ADDR, out, 23 ([23:1]): flash address.
- DQ_OUT, out, 16: data driven to flash.
- DQ_DRV, out, 1: tristate enable for DQ_OUT, used at top level.
- DQ_IN, in, 16: data read back from flash.
- OE, WE, CE, RP, out, 1 each: flash controls, all active-low.
- MTCE, out, 1: RAM chip enable, held high (RAM disabled).

Function
REQ-005 Accept PROG_GO/ERASE_GO only in IDLE; ignore both when BUSY=1; if both are asserted together, ERASE_GO wins.
REQ-006 Latch PROG_ADDR/PROG_DATA on the accept cycle; later input changes do not affect the operation in progress.
REQ-007 FSM states:
- IDLE
- WR_SETUP
- WR_PULSE
- WR_HOLD
- WR_GAP
- POLL_RD
- POLL_CHK
- CLR_SR
- RD_ARRAY
- FIN
REQ-008 Every bus write cycle runs in this order:
- WR_SETUP: 1 cycle; CE=0, ADDR and DQ_OUT stable, DQ_DRV=1, WE=1.
- WR_PULSE: WE_CYC cycles with WE=0.
- WR_HOLD: 1 cycle; WE=1, data still driven.
- WR_GAP: 1 cycle; CE=1, DQ_DRV=0.
REQ-009 Program sequence: write 0x0040 at addr, then write PROG_DATA at addr, then poll.
REQ-010 Erase sequence: write 0x0020 at addr, then write 0x00D0 at addr, then poll.
REQ-011 Poll behaviour:
- POLL_RD holds CE=0, OE=0, DQ_DRV=0 for RD_CYC cycles, then samples DQ_IN.
- POLL_CHK: if SR7=0, return to POLL_RD (with OE=1 for 1 cycle between reads).
- If SR7=1 and SR5|SR4|SR3=0: success.
REQ-012 If SR7=1 and any of SR5, SR4, SR3 is set: set ERR, load ERR_CODE, and issue write 0x0050 (CLR_SR).
REQ-013 Poll counter timeout: on reaching POLL_MAX, set ERR with ERR_CODE=3'b111 and proceed to CLR_SR.
REQ-014 Every operation ends with write 0x00FF (RD_ARRAY), then FIN.
- FIN pulses DONE for 1 cycle and returns to IDLE.
- BUSY=1 from the cycle after accept through FIN inclusive.
REQ-015 ERR clears only on RST or on acceptance of a new operation.
REQ-016 DQ_DRV=1 and OE=0 never occur in the same cycle; OE=0 and WE=0 never occur in the same cycle.
REQ-017 RP=1 at all times after reset.

Reset
REQ-018 When RST=1 at a CLK edge, the block enters this state regardless of the current state, including mid-pulse:
- State: IDLE.
- WE=1, OE=1, CE=1, DQ_DRV=0, MTCE=1, RP=1.
- BUSY=0, DONE=0, ERR=0, ERR_CODE=0.
- ADDR=0, DQ_OUT=0, all counters 0.
REQ-019 No bus cycle starts in the cycle in which RST deasserts.

Configuration
REQ-020 Macro FLASH_ERASE_EN.
- Defined: erase sequence (REQ-010) is supported.
- Undefined: ERASE_GO is ignored, erase command constants and states are not compiled, and PROG_GO alone is serviced.

Structure
REQ-021 Package flash_pkg holds:
- Command constants: 0x0040, 0x0020, 0x00D0, 0x0050, 0x00FF.
- Status bit indices SR7, SR5, SR4, SR3.
- The FSM state enumeration.
REQ-022 One sub-module, flash_wr_cycle, implements the four-phase write cycle of REQ-008 with a start/ack handshake; the main FSM sequences command words through it.

Verification
REQ-023 The bench covers these directed scenarios (stimulus -> required response):
- Program: PROG_GO, addr 0x000010, data 0xA5C3; flash model ready after 3 polls -> bus writes 0x0040, 0xA5C3, 0x00FF; WE low 7 cycles each; DONE=1 once; ERR=0.
- Erase: ERASE_GO, addr 0x010000 (FLASH_ERASE_EN defined) -> bus writes 0x0020, 0x00D0, polls, 0x00FF; DONE=1.
- Program error: model returns status 0x0090 -> ERR=1, ERR_CODE=3'b010, 0x0050 then 0x00FF written, DONE=1.
- Timeout: POLL_MAX=16, SR7 stuck at 0 -> ERR_CODE=3'b111 after 16 polls, DONE=1.
- Busy/reset: PROG_GO while BUSY -> ignored; RST asserted during WR_PULSE -> next cycle WE=1, CE=1, BUSY=0.
- Erase compiled out: FLASH_ERASE_EN undefined, ERASE_GO -> no bus activity, BUSY stays 0.
